// File: rtl/grouped_update_sequencer.sv
// Steps through colour groups, driving each group's stored p-bit mask for a
// programmable dwell, for a fixed number of sweeps or until stopped.
module grouped_update_sequencer #(
    parameter int N_PBITS  = 994,
    parameter int N_GROUPS = 5,
    parameter int DWELL_W  = 8,
    parameter int SWEEP_W  = 16,
    localparam int GROUP_W = (N_GROUPS > 2) ? $clog2(N_GROUPS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [GROUP_W-1:0] cfg_group,
    input  logic [N_PBITS-1:0] cfg_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SWEEP_W-1:0] n_sweeps,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [GROUP_W-1:0] group_EN,
    output logic               group_strobe,
    output logic [N_PBITS-1:0] Pbit_EN,
    output logic [SWEEP_W-1:0] sweep_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(N_GROUPS - 1);

    state_t             state_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic [DWELL_W-1:0] cnt_reg;
    logic [SWEEP_W-1:0] nsweeps_reg;

    logic [N_PBITS-1:0] mask_rows [N_GROUPS];
    logic               grp_valid;
    logic               wr_ok;
    logic               dwell_end;
    logic               last_group;
    logic               finish_now;
    logic [GROUP_W-1:0] next_group;
    logic [SWEEP_W-1:0] sweep_next;

    assign grp_valid = int'(cfg_group) < N_GROUPS;
    assign wr_ok     = cfg_we && (state_reg != S_RUN) && grp_valid;

    // One register row per group; rows are frozen while the sequence runs.
    genvar gi;
    generate
        for (gi = 0; gi < N_GROUPS; gi++) begin : g_row
            logic [N_PBITS-1:0] row_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    row_reg <= '0;
                end else if (wr_ok && (cfg_group == GROUP_W'(gi))) begin
                    row_reg <= cfg_mask;
                end
            end

            assign mask_rows[gi] = row_reg;
        end
    endgenerate

    assign dwell_end  = (cnt_reg == dwell_reg);
    assign last_group = (group_EN == LAST_GROUP);
    assign next_group = last_group ? '0 : group_EN + GROUP_W'(1);
    assign sweep_next = (&sweep_count) ? sweep_count : sweep_count + SWEEP_W'(1);
    // The wrap that completes the requested sweep count ends the run.
    assign finish_now = dwell_end && last_group && (nsweeps_reg != '0) &&
                        (sweep_next == nsweeps_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            dwell_reg    <= '0;
            cnt_reg      <= '0;
            nsweeps_reg  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            group_EN     <= '0;
            group_strobe <= 1'b0;
            Pbit_EN      <= '0;
            sweep_count  <= '0;
        end else begin
            cfg_err      <= cfg_we && ((state_reg == S_RUN) || !grp_valid);
            done         <= 1'b0;
            group_strobe <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_reg    <= S_RUN;
                        busy         <= 1'b1;
                        group_EN     <= '0;
                        Pbit_EN      <= mask_rows[0];
                        group_strobe <= 1'b1;
                        sweep_count  <= '0;
                        cnt_reg      <= DWELL_W'(1);
                        dwell_reg    <= (dwell == '0) ? DWELL_W'(1) : dwell;
                        nsweeps_reg  <= n_sweeps;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                        Pbit_EN   <= '0;
                        group_EN  <= '0;
                    end else if (dwell_end) begin
                        cnt_reg <= DWELL_W'(1);
                        if (last_group) begin
                            sweep_count <= sweep_next;
                        end
                        if (finish_now) begin
                            state_reg <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            Pbit_EN   <= '0;
                            group_EN  <= '0;
                        end else begin
                            group_EN     <= next_group;
                            Pbit_EN      <= mask_rows[next_group];
                            group_strobe <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DWELL_W'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grouped_update_sequencer.sv
// Directed and randomized checks of grouped_update_sequencer against an
// elapsed-cycle reference model (N_PBITS=8, N_GROUPS=3).
module tb_grouped_update_sequencer;

    localparam int NP = 8;
    localparam int NG = 3;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int GW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [GW-1:0] cfg_group;
    logic [NP-1:0] cfg_mask;
    logic [DW-1:0] dwell;
    logic [SW-1:0] n_sweeps;
    logic          start;
    logic          stop;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [GW-1:0] group_EN;
    logic          group_strobe;
    logic [NP-1:0] Pbit_EN;
    logic [SW-1:0] sweep_count;

    grouped_update_sequencer #(
        .N_PBITS (NP),
        .N_GROUPS(NG),
        .DWELL_W (DW),
        .SWEEP_W (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_group   (cfg_group),
        .cfg_mask    (cfg_mask),
        .dwell       (dwell),
        .n_sweeps    (n_sweeps),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .group_EN    (group_EN),
        .group_strobe(group_strobe),
        .Pbit_EN     (Pbit_EN),
        .sweep_count (sweep_count)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model: mode 0=idle 1=run 2=done; m_k = cycles elapsed since start.
    int            m_st   = 0;
    int            m_k    = 0;
    int            m_d    = 1;
    int            m_n    = 0;
    int            m_hold = 0;
    logic [NP-1:0] m_rows [NG];
    bit            m_err  = 1'b0;
    bit            m_rst  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step();
        int sw;
        if (rst) begin
            m_st = 0; m_k = 0; m_d = 1; m_n = 0; m_hold = 0;
            m_err = 1'b0; m_rst = 1'b1;
            for (int i = 0; i < NG; i++) m_rows[i] = '0;
            return;
        end
        m_rst = 1'b0;
        m_err = cfg_we && (m_st == 1 || int'(cfg_group) >= NG);
        if (cfg_we && m_st != 1 && int'(cfg_group) < NG) m_rows[cfg_group] = cfg_mask;
        case (m_st)
            0: if (start && !stop) begin
                m_st = 1; m_k = 0; m_hold = 0;
                m_d = (dwell == 0) ? 1 : int'(dwell);
                m_n = int'(n_sweeps);
            end
            1: if (stop) m_st = 0;
               else begin
                   m_k++;
                   if (m_n != 0 && m_k == m_n * m_d * NG) m_st = 2;
               end
            default: m_st = 0;
        endcase
        if (m_st == 1) begin
            sw = m_k / (NG * m_d);
            m_hold = (sw > 15) ? 15 : sw;
        end else if (m_st == 2) begin
            m_hold = m_n;
        end
    endtask

    task automatic compare_all();
        int g;
        g = (m_k / m_d) % NG;
        check_val("busy", 32'(busy), 32'(m_st == 1));
        check_val("done", 32'(done), 32'(m_st == 2));
        check_val("cfg_err", 32'(cfg_err), 32'(m_err));
        check_val("group_strobe", 32'(group_strobe), 32'(m_st == 1 && (m_k % m_d) == 0));
        check_val("Pbit_EN", 32'(Pbit_EN), (m_st == 1) ? 32'(m_rows[g]) : 32'd0);
        check_val("sweep_count", 32'(sweep_count), 32'(m_hold));
        if (m_st == 1 || m_rst) check_val("group_EN", 32'(group_EN), (m_st == 1) ? 32'(g) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic write_row(input int g, input logic [NP-1:0] m);
        cfg_we = 1'b1; cfg_group = GW'(g); cfg_mask = m;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int d, input int n);
        dwell = DW'(d); n_sweeps = SW'(n); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_group = '0; cfg_mask = '0;
        dwell = '0; n_sweeps = '0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < NG; i++) m_rows[i] = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Two-sweep-free single pass with dwell 2
        write_row(0, 8'h81);
        write_row(1, 8'h42);
        write_row(2, 8'h24);
        do_start(2, 1);
        repeat (8) step();

        // Free-run with dwell 0, stopped after ten cycles
        do_start(0, 0);
        repeat (9) step();
        do_stop();
        repeat (2) step();

        // Write blocked while running, accepted in idle
        do_start(3, 0);
        write_row(1, 8'hFF);
        step();
        do_stop();
        step();
        write_row(1, 8'hFF);
        step();

        // Out-of-range row address
        write_row(3, 8'h55);
        step();

        // Simultaneous start and stop from idle
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();

        // Reset in the second dwell cycle of group 1, then restart without reload
        write_row(1, 8'h42);
        do_start(2, 0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_start(2, 0);
        repeat (4) step();
        do_stop();

        // Sweep counter saturation in free-run
        write_row(0, 8'h11);
        write_row(1, 8'h22);
        write_row(2, 8'h44);
        do_start(0, 0);
        repeat (60) step();
        do_stop();
        step();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom % 200) == 0;
            start     = ($urandom % 10) == 0;
            stop      = ($urandom % 40) == 0;
            cfg_we    = !start && (($urandom % 8) == 0);
            cfg_group = GW'($urandom % 4);
            cfg_mask  = NP'($urandom);
            dwell     = DW'($urandom % 4);
            n_sweeps  = SW'($urandom % 4);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
